toggle_divider: RTL and testbench

Parametrised falling-edge programmable toggle divider for the processor's timing utilities. Generalises the single toggle flip-flop into a WIDTH-bit loadable half-period counter that inverts `q` every `div+1` enabled cycles and emits a one-cycle `tick` at each inversion. Drives game-timer, blink and mole-lifetime timebases from the system clock without extra clock domains.

---
 rtl/toggle_divider_pkg.sv | 17 +
 rtl/toggle_divider.sv | 93 +++++++++
 tb/tb_toggle_divider.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/toggle_divider_pkg.sv
// toggle_divider_pkg
//   Shared constants for the programmable toggle divider: the default
//   divisor/counter width and the values every register returns to on clr.
//   No ports; imported by toggle_divider.
package toggle_divider_pkg;

    // Default width of the divisor register and the half-period counter.
    localparam int unsigned TD_DEFAULT_WIDTH = 16;

    // Reset values. A cleared divider behaves as a plain toggle flip-flop
    // (div_r = 0 toggles q on every enabled edge).
    localparam logic        Q_RST     = 1'b0;
    localparam logic        TICK_RST  = 1'b0;
    localparam int unsigned CNT_RST   = 0;
    localparam int unsigned DIV_R_RST = 0;

endpackage

// File: rtl/toggle_divider.sv
// toggle_divider
//   Falling-edge programmable toggle divider. A WIDTH-bit loadable
//   half-period counter inverts q every div_r+1 enabled edges and raises a
//   one-cycle tick on each inversion. All state changes on the falling edge
//   of clk; every output is registered.
//
//   Optional feature (compile-time macro TOGGLE_DIVIDER_ONESHOT_EN): adds the
//   oneshot input and an internal armed flag so that a single toggle can be
//   produced per load.
//
// Ports
//   clk      in   1      clock, all state updates on its falling edge
//   clr      in   1      synchronous active-high clear (sampled on falling edge)
//   en       in   1      count enable
//   load     in   1      latch div into div_r and restart the count
//   div      in   WIDTH  half-period minus one (0 => toggle every enabled edge)
//   oneshot  in   1      only with TOGGLE_DIVIDER_ONESHOT_EN
//   q        out  1      divided output
//   tick     out  1      one-cycle pulse on each q inversion
//   count    out  WIDTH  current counter value (debug visibility)
module toggle_divider
    import toggle_divider_pkg::*;
#(
    parameter int unsigned WIDTH = TD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
`ifdef TOGGLE_DIVIDER_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic             q,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] cnt;
    logic             terminal;
    logic             hold;

    // Equality compare only: cnt is restarted at div_r, so it can never run
    // past the divisor, and the all-ones divisor wraps cleanly to 0.
    assign terminal = (cnt == div_r);
    assign count    = cnt;

`ifdef TOGGLE_DIVIDER_ONESHOT_EN
    logic armed;

    // A disarmed one-shot freezes the counter until the next load.
    assign hold = oneshot && !armed;

    always_ff @(negedge clk) begin
        if (clr) begin
            armed <= 1'b0;
        end else if (load) begin
            armed <= 1'b1;
        end else if (en && oneshot && armed && terminal) begin
            armed <= 1'b0;
        end
    end
`else
    assign hold = 1'b0;
`endif

    always_ff @(negedge clk) begin
        if (clr) begin
            q     <= Q_RST;
            tick  <= TICK_RST;
            cnt   <= WIDTH'(CNT_RST);
            div_r <= WIDTH'(DIV_R_RST);
        end else if (load) begin
            // Load wins over a coincident terminal count: restart, no toggle.
            div_r <= div;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (en && !hold) begin
            if (terminal) begin
                cnt  <= '0;
                q    <= ~q;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_divider.sv
// tb_toggle_divider
//   Directed self-checking bench for toggle_divider. Two instances share the
//   control inputs: a default-width one and a WIDTH=4 one used for the
//   maximum-divisor case. Inputs change 1 time unit after a falling edge and
//   outputs are sampled at the same point, away from the active edge.
module tb_toggle_divider;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        load;
    logic [15:0] div;
    logic        oneshot;
    logic        q;
    logic        tick;
    logic [15:0] count;
    logic        q4;
    logic        tick4;
    logic [3:0]  count4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    toggle_divider dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .load    (load),
        .div     (div),
`ifdef TOGGLE_DIVIDER_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .q       (q),
        .tick    (tick),
        .count   (count)
    );

    toggle_divider #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .load    (load),
        .div     (div[3:0]),
`ifdef TOGGLE_DIVIDER_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .q       (q4),
        .tick    (tick4),
        .count   (count4)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic eq, input logic et, input logic [15:0] ec);
        check({tag, ".q"},     {31'd0, q},    {31'd0, eq});
        check({tag, ".tick"},  {31'd0, tick}, {31'd0, et});
        check({tag, ".count"}, {16'd0, count}, {16'd0, ec});
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; load = 1'b0; div = 16'd0; oneshot = 1'b0;
        #1;

        // Clear from power-up.
        step();
        check_out("rst0", 1'b0, 1'b0, 16'd0);
        check("rst0.count4", {28'd0, count4}, 32'd0);

        // Build some non-reset state, then clear for a single edge.
        clr = 1'b0; en = 1'b1; load = 1'b1; div = 16'd3;
        step();
        load = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        check_out("pre_clr", 1'b1, 1'b1, 16'd0);
        clr = 1'b1;
        step();
        check_out("clr", 1'b0, 1'b0, 16'd0);
        check("clr.q4", {31'd0, q4}, 32'd0);

        // div_r = 0 after clear: toggle every enabled edge, tick held high.
        clr = 1'b0; en = 1'b1;
        step(); check_out("div0_e1", 1'b1, 1'b1, 16'd0);
        step(); check_out("div0_e2", 1'b0, 1'b1, 16'd0);
        step(); check_out("div0_e3", 1'b1, 1'b1, 16'd0);
        step(); check_out("div0_e4", 1'b0, 1'b1, 16'd0);

        // div = 3: toggles at edges 4, 8, 12 after the load edge.
        load = 1'b1; div = 16'd3;
        step(); check_out("ld3", 1'b0, 1'b0, 16'd0);
        load = 1'b0;
        step(); check_out("d3_e1",  1'b0, 1'b0, 16'd1);
        step(); check_out("d3_e2",  1'b0, 1'b0, 16'd2);
        step(); check_out("d3_e3",  1'b0, 1'b0, 16'd3);
        step(); check_out("d3_e4",  1'b1, 1'b1, 16'd0);
        step(); check_out("d3_e5",  1'b1, 1'b0, 16'd1);
        step(); step();
        step(); check_out("d3_e8",  1'b0, 1'b1, 16'd0);
        step(); step(); step();
        step(); check_out("d3_e12", 1'b1, 1'b1, 16'd0);

        // Enable gating mid-count with div = 2.
        load = 1'b1; div = 16'd2;
        step(); check_out("ld2", 1'b1, 1'b0, 16'd0);
        load = 1'b0;
        step(); check_out("d2_e1", 1'b1, 1'b0, 16'd1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(); check_out("en_low", 1'b1, 1'b0, 16'd1);
        end
        en = 1'b1;
        step(); check_out("resume1", 1'b1, 1'b0, 16'd2);
        step(); check_out("resume2", 1'b0, 1'b1, 16'd0);

        // Load collides with a terminal count: no toggle, counter restarts.
        step(); step();
        check_out("at_term", 1'b0, 1'b0, 16'd2);
        load = 1'b1; div = 16'd5;
        step(); check_out("ld_coll", 1'b0, 1'b0, 16'd0);
        load = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        check_out("d5_e5", 1'b0, 1'b0, 16'd5);
        step(); check_out("d5_e6", 1'b1, 1'b1, 16'd0);

        // Changing div without load leaves div_r = 5 in force.
        div = 16'd1;
        step(); check_out("nold_e1", 1'b1, 1'b0, 16'd1);
        step(); check_out("nold_e2", 1'b1, 1'b0, 16'd2);

        // Maximum divisor on the 4-bit instance: half-period of 16 edges.
        load = 1'b1; div = 16'd15;
        step(); check("max_ld.count4", {28'd0, count4}, 32'd0);
        load = 1'b0;
        for (int k = 1; k <= 15; k++) step();
        check("max_e15.count4", {28'd0, count4}, 32'd15);
        check("max_e15.q4",     {31'd0, q4},     32'd1);
        check("max_e15.tick4",  {31'd0, tick4},  32'd0);
        step();
        check("max_e16.count4", {28'd0, count4}, 32'd0);
        check("max_e16.q4",     {31'd0, q4},     32'd0);
        check("max_e16.tick4",  {31'd0, tick4},  32'd1);
        check_out("w16_e16", 1'b0, 1'b1, 16'd0);
        step();
        check("max_e17.count4", {28'd0, count4}, 32'd1);
        check("max_e17.tick4",  {31'd0, tick4},  32'd0);

`ifdef TOGGLE_DIVIDER_ONESHOT_EN
        // One-shot: single toggle at edge 3 after load, then frozen.
        oneshot = 1'b1; load = 1'b1; div = 16'd2;
        step(); check_out("os_ld", 1'b0, 1'b0, 16'd0);
        load = 1'b0;
        step(); step();
        check_out("os_e2", 1'b0, 1'b0, 16'd2);
        step(); check_out("os_e3", 1'b1, 1'b1, 16'd0);
        for (int k = 0; k < 20; k++) begin
            step(); check_out("os_hold", 1'b1, 1'b0, 16'd0);
        end
        load = 1'b1;
        step(); check_out("os_reld", 1'b1, 1'b0, 16'd0);
        load = 1'b0;
        step(); step();
        step(); check_out("os_rearm", 1'b0, 1'b1, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
